player_bullet: RTL and testbench

//  Player missile stage, directly downstream of the player ship block.

---
 rtl/player_bullet.sv | 141 ++++++++++++++
 tb/tb_player_bullet.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_bullet.sv
// Player missile: launches from the ship centre, climbs the playfield,
// retires on an enemy hit or at the top border, then cools down.
module player_bullet #(
  parameter logic [11:0] color_p    = 12'hFFF,
  parameter logic [9:0]  start_y_p  = 10'd440,
  parameter logic [9:0]  top_y_p    = 10'd8,
  parameter logic [19:0] step_div_p = 20'd400000,
  parameter logic [9:0]  step_px_p  = 10'd4,
  parameter logic [19:0] cooldown_p = 20'd2000000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        shoot_i,
  input  logic        alive_i,
  input  logic        freeze_i,
  input  logic [9:0]  player_left_i,
  input  logic [9:0]  player_right_i,
  input  logic        hit_enemy_i,
  output logic        active_o,
  output logic [9:0]  bullet_x_o,
  output logic [9:0]  bullet_y_o,
  output logic        fired_o,
  output logic [11:0] color_o
);

  typedef enum logic [1:0] {
    IDLE,
    FLY,
    COOL
  } state_t;

  localparam logic [19:0] step_last = step_div_p - 20'd1;
  localparam logic [19:0] cool_last = cooldown_p - 20'd1;
  localparam logic [10:0] top_lim  =
    {1'b0, top_y_p} + {1'b0, step_px_p};

  state_t      state_q, state_d;
  logic        shoot_q;
  logic        fire_req;
  logic [19:0] step_q, step_d;
  logic [19:0] cool_q, cool_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        fired_q, fired_d;
  logic [10:0] x_sum;
  logic        at_top;

  assign fire_req = shoot_i & ~shoot_q;
  assign x_sum    = {1'b0, player_left_i}
                  + {1'b0, player_right_i};
  assign at_top   = {1'b0, y_q} < top_lim;

  // State, counters and bullet position registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      shoot_q <= 1'b0;
      step_q  <= '0;
      cool_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      fired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shoot_q <= shoot_i;
      step_q  <= step_d;
      cool_q  <= cool_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fired_q <= fired_d;
    end
  end

  // Next state: death beats hit, hit beats a same-cycle step
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cool_d  = cool_q;
    x_d     = x_q;
    y_d     = y_q;
    fired_d = 1'b0;
    if (!alive_i) begin
      state_d = IDLE;
      step_d  = '0;
      cool_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fire_req && !freeze_i) begin
            state_d = FLY;
            x_d     = x_sum[10:1];
            y_d     = start_y_p;
            step_d  = '0;
            fired_d = 1'b1;
          end
        end
        FLY: begin
          if (hit_enemy_i) begin
            state_d = COOL;
            step_d  = '0;
            cool_d  = '0;
          end else if (!freeze_i) begin
            if (step_q == step_last) begin
              step_d = '0;
              if (at_top) begin
                state_d = COOL;
                cool_d  = '0;
              end else begin
                y_d = y_q - step_px_p;
              end
            end else begin
              step_d = step_q + 20'd1;
            end
          end
        end
        COOL: begin
          if (!freeze_i) begin
            if (cool_q == cool_last) begin
              state_d = IDLE;
              cool_d  = '0;
            end else begin
              cool_d = cool_q + 20'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          step_d  = '0;
          cool_d  = '0;
        end
      endcase
    end
  end

  assign active_o   = (state_q == FLY);
  assign bullet_x_o = x_q;
  assign bullet_y_o = y_q;
  assign fired_o    = fired_q;
  assign color_o    = active_o ? color_p : 12'h000;

endmodule

// File: tb/tb_player_bullet.sv
// Bench for player_bullet: directed flight scenarios plus random
// traffic, all outputs compared each cycle against a flight model.
module tb_player_bullet;

  localparam int START = 440;
  localparam int TOP   = 8;
  localparam int DIV   = 4;
  localparam int PX    = 4;
  localparam int COOLN = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        shoot;
  logic        alive;
  logic        freeze;
  logic [9:0]  left;
  logic [9:0]  right;
  logic        hit;
  logic        active_o;
  logic [9:0]  bullet_x_o;
  logic [9:0]  bullet_y_o;
  logic        fired_o;
  logic [11:0] color_o;

  int n_vec = 0;
  int n_err = 0;

  // model: 0 idle, 1 flying, 2 cooling
  int m_mode = 0;
  int m_x = 0;
  int m_y = 0;
  int m_age = 0;
  int m_cool = 0;
  int m_fired = 0;
  bit m_sq = 1'b0;

  always #5 clk = ~clk;

  player_bullet #(
    .color_p   (12'hFFF),
    .start_y_p (10'd440),
    .top_y_p   (10'd8),
    .step_div_p(20'd4),
    .step_px_p (10'd4),
    .cooldown_p(20'd3)
  ) dut (
    .clk_i         (clk),
    .reset_i       (rst),
    .shoot_i       (shoot),
    .alive_i       (alive),
    .freeze_i      (freeze),
    .player_left_i (left),
    .player_right_i(right),
    .hit_enemy_i   (hit),
    .active_o      (active_o),
    .bullet_x_o    (bullet_x_o),
    .bullet_y_o    (bullet_y_o),
    .fired_o       (fired_o),
    .color_o       (color_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model();
    bit fire;
    fire = shoot && !m_sq;
    m_sq = shoot;
    m_fired = 0;
    if (rst) begin
      m_mode = 0; m_x = 0; m_y = 0;
      m_age = 0; m_cool = 0; m_sq = 1'b0;
    end else if (!alive) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (fire && !freeze) begin
        m_mode = 1;
        m_x = (int'(left) + int'(right)) / 2;
        m_y = START;
        m_age = 0;
        m_fired = 1;
      end
    end else if (m_mode == 1) begin
      if (hit) begin
        m_mode = 2;
        m_cool = COOLN;
      end else if (!freeze) begin
        m_age++;
        if (m_age % DIV == 0) begin
          if (m_y < TOP + PX) begin
            m_mode = 2;
            m_cool = COOLN;
          end else begin
            m_y = m_y - PX;
          end
        end
      end
    end else begin
      if (!freeze) begin
        m_cool--;
        if (m_cool == 0) m_mode = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    #1;
    chk("active", active_o, m_mode == 1);
    chk("fired", fired_o, m_fired);
    chk("x", bullet_x_o, m_x);
    chk("y", bullet_y_o, m_y);
    chk("color", color_o, (m_mode == 1) ? 12'hFFF : 12'h0);
    if (active_o)
      chk("y_floor", bullet_y_o >= 10'd8, 1);
  endtask

  int   pulses;
  int   budget;
  int   life;
  int   last_y;
  logic [9:0] y0;

  initial begin
    rst = 1'b1; shoot = 1'b0; alive = 1'b1;
    freeze = 1'b0; hit = 1'b0;
    left = 10'd0; right = 10'd0;
    #2;
    // 1: reset with random inputs
    for (int i = 0; i < 2; i++) begin
      shoot = 1'($urandom); alive = 1'($urandom);
      freeze = 1'($urandom); hit = 1'($urandom);
      left = 10'($urandom); right = 10'($urandom);
      tick();
    end
    chk("rst_active", active_o, 0);
    chk("rst_fired", fired_o, 0);
    chk("rst_x", bullet_x_o, 0);
    chk("rst_y", bullet_y_o, 0);
    chk("rst_color", color_o, 0);

    // 2: launch from ship centre, first steps
    rst = 1'b0; shoot = 1'b0; alive = 1'b1;
    freeze = 1'b0; hit = 1'b0;
    left = 10'd250; right = 10'd285;
    repeat (9) tick();
    shoot = 1'b1;
    tick();
    chk("t2_active", active_o, 1);
    chk("t2_fired", fired_o, 1);
    chk("t2_x", bullet_x_o, 267);
    chk("t2_y", bullet_y_o, 440);
    pulses = 1;
    tick();
    chk("t2_fired_off", fired_o, 0);
    repeat (3) tick();
    chk("t2_y436", bullet_y_o, 436);
    repeat (4) tick();
    chk("t2_y432", bullet_y_o, 432);

    // 3: held button, release and re-press in flight
    for (int i = 0; i < 41; i++) begin
      left = 10'($urandom); right = 10'($urandom);
      tick();
      if (fired_o) pulses++;
    end
    shoot = 1'b0;
    repeat (2) tick();
    shoot = 1'b1;
    repeat (2) begin tick(); if (fired_o) pulses++; end
    chk("t3_pulses", pulses, 1);
    chk("t3_x_fixed", bullet_x_o, 267);

    // end this flight, relaunch for the hit test
    shoot = 1'b0; hit = 1'b1;
    tick();
    hit = 1'b0;
    repeat (5) tick();
    left = 10'd100; right = 10'd201;
    shoot = 1'b1;
    tick();
    chk("t4_launch", fired_o, 1);
    chk("t4_x", bullet_x_o, 150);

    // 4: hit at y=420, shots during cooldown dropped
    budget = 100;
    while (bullet_y_o != 10'd420 && budget > 0) begin
      tick();
      budget--;
    end
    chk("t4_reach420", budget > 0, 1);
    hit = 1'b1; shoot = 1'b0;
    tick();
    hit = 1'b0;
    chk("t4_retired", active_o, 0);
    chk("t4_y_kept", bullet_y_o, 420);
    tick();
    shoot = 1'b1;
    tick();
    chk("t4_cool_drop", fired_o, 0);
    shoot = 1'b0;
    tick();
    shoot = 1'b1;
    tick();
    chk("t4_relaunch", fired_o, 1);

    // 5: free flight to the top border
    life = 0; last_y = 0;
    while (active_o && life < 1000) begin
      last_y = int'(bullet_y_o);
      tick();
      life++;
    end
    chk("t5_life", life, 436);
    chk("t5_last_y", last_y, 8);

    // 6: freeze mid-flight, then death
    shoot = 1'b0;
    repeat (5) tick();
    shoot = 1'b1;
    tick();
    chk("t6_launch", fired_o, 1);
    repeat (9) tick();
    y0 = bullet_y_o;
    freeze = 1'b1;
    for (int i = 0; i < 10; i++) begin
      shoot = 1'($urandom);
      tick();
    end
    chk("t6_frozen_y", bullet_y_o, y0);
    chk("t6_frozen_act", active_o, 1);
    freeze = 1'b0;
    repeat (7) tick();
    alive = 1'b0;
    tick();
    chk("t6_dead", active_o, 0);
    shoot = 1'b0;
    tick();
    shoot = 1'b1;
    tick();
    chk("t6_dead_noshot", fired_o, 0);
    alive = 1'b1; shoot = 1'b0;
    tick();

    // random traffic
    for (int i = 0; i < 6000; i++) begin
      rst    = ($urandom_range(0, 499) == 0);
      shoot  = ($urandom_range(0, 3) == 0);
      alive  = ($urandom_range(0, 59) != 0);
      freeze = ($urandom_range(0, 9) == 0);
      hit    = ($urandom_range(0, 99) == 0);
      left   = 10'($urandom);
      right  = 10'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
